// File: rtl/pc_seq_pkg.sv
// pc_seq_pkg: shared state encoding and helpers for the PC step sequencer
package pc_seq_pkg;
  typedef enum logic [1:0] {ST_STEP, ST_RUN, ST_HALTED} state_t;
  function automatic int clog2(input longint unsigned v);
    int r = 0;
    while ((64'd1 << r) < v) r++;
    return r;
  endfunction
  function automatic logic [63:0] align_mask(input int bytes);
    return ~(64'(bytes) - 64'd1);
  endfunction
endpackage

// File: rtl/step_debouncer.sv
// step_debouncer: synchronise active-low button, debounce, emit one pulse per accepted press
module step_debouncer
  import pc_seq_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic rst,
  input  logic button,
  output logic press
);
  localparam int CW = clog2(longint'(DEB_CYCLES) + 1);
  logic [1:0] sync_q, sync_d;
  logic stable_q, stable_d, press_q, press_d, accept;
  logic [CW-1:0] cnt_q, cnt_d;
  // Sync/stable flops come out of reset as "pressed" so a held button needs a release first
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      sync_q   <= 2'b11;
      stable_q <= 1'b1;
      cnt_q    <= '0;
      press_q  <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      stable_q <= stable_d;
      cnt_q    <= cnt_d;
      press_q  <= press_d;
    end
  // Count cycles the synced level differs from the accepted one; any bounce back restarts it
  always_comb begin
    sync_d   = {sync_q[0], ~button};
    accept   = sync_q[1] != stable_q && cnt_q == CW'(DEB_CYCLES - 1);
    cnt_d    = (sync_q[1] == stable_q || accept) ? '0 : cnt_q + CW'(1);
    stable_d = accept ? sync_q[1] : stable_q;
    press_d  = accept && sync_q[1];
  end
  assign press = press_q;
endmodule

// File: rtl/pc_step_sequencer.sv
// pc_step_sequencer: synchronous PC with single-step/free-run, branch load, wrap and breakpoint halt
module pc_step_sequencer
  import pc_seq_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter int              INSTR_BYTES  = 4,
  parameter longint unsigned RESET_VECTOR = 0,
  parameter longint unsigned PC_LIMIT     = 1024,
  parameter int              DEB_CYCLES   = 500000,
  parameter int              RUN_DIV      = 50
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic                                     button,
  input  logic                                     run_mode,
  input  logic                                     resume,
  input  logic                                     branch_valid,
  input  logic [ADDR_W-1:0]                        branch_target,
  input  logic                                     bp_en,
  input  logic [ADDR_W-1:0]                        bp_addr,
  output logic [ADDR_W-1:0]                        pc_address,
  output logic [ADDR_W-clog2(INSTR_BYTES)-1:0]     word_address,
  output logic                                     step_pulse,
  output logic                                     halted
);
  localparam int SH = clog2(INSTR_BYTES);
  localparam int DW = clog2(longint'(RUN_DIV) + 1);
  localparam logic [ADDR_W-1:0] MASK  = ADDR_W'(align_mask(INSTR_BYTES));
  localparam logic [ADDR_W-1:0] LIMIT = ADDR_W'(PC_LIMIT);
  localparam logic [ADDR_W-1:0] RV    = ADDR_W'(RESET_VECTOR);
  state_t state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, cand, next_pc;
  logic [DW-1:0] div_q, div_d;
  logic [1:0] rst_sync_q, rst_sync_d;
  logic prev_run_q, prev_run_d, skip_q, skip_d;
  logic rst_i, press, step_req, bp_hit;
  // Reset asserts immediately but is released on a clock edge
  always_comb rst_sync_d = {rst_sync_q[0], 1'b0};
  always_ff @(posedge clk or posedge rst)
    if (rst) rst_sync_q <= 2'b11;
    else rst_sync_q <= rst_sync_d;
  assign rst_i = rst_sync_q[1];
  step_debouncer #(.DEB_CYCLES(DEB_CYCLES)) u_deb (
    .clk   (clk),
    .rst   (rst_i),
    .button(button),
    .press (press)
  );
  // State register: FSM, PC, run divider and resume bookkeeping
  always_ff @(posedge clk or posedge rst_i)
    if (rst_i) begin
      state_q    <= ST_STEP;
      pc_q       <= RV;
      div_q      <= '0;
      prev_run_q <= 1'b0;
      skip_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      div_q      <= div_d;
      prev_run_q <= prev_run_d;
      skip_q     <= skip_d;
    end
  // Next state: step request, next PC with wrap, breakpoint (skipped once after resume)
  always_comb begin
    step_req   = !resume && ((state_q == ST_STEP && press) ||
                             (state_q == ST_RUN && div_q == DW'(RUN_DIV - 1)));
    cand       = branch_valid ? (branch_target & MASK) : pc_q + ADDR_W'(INSTR_BYTES);
    next_pc    = cand >= LIMIT ? RV : cand;
    bp_hit     = step_req && bp_en && next_pc == bp_addr && !(skip_q && next_pc == pc_q);
    pc_d       = step_req ? next_pc : pc_q;
    skip_d     = (state_q == ST_HALTED && resume) ? 1'b1 :
                 (step_req && next_pc != pc_q) ? 1'b0 : skip_q;
    prev_run_d = state_q == ST_HALTED ? prev_run_q : state_q == ST_RUN;
    div_d      = (state_q == ST_RUN && div_q != DW'(RUN_DIV - 1)) ? div_q + DW'(1) : '0;
    state_d    = state_q == ST_HALTED ? (resume ? (prev_run_q ? ST_RUN : ST_STEP) : ST_HALTED) :
                 bp_hit ? ST_HALTED : run_mode ? ST_RUN : ST_STEP;
  end
  // Outputs: pulse marks the cycle whose closing edge loads the new PC
  always_comb begin
    step_pulse   = step_req;
    halted       = state_q == ST_HALTED;
    pc_address   = pc_q;
    word_address = pc_q[ADDR_W-1:SH];
  end
endmodule

// File: tb/tb_pc_step_sequencer.sv
// tb_pc_step_sequencer: directed vectors and corner sequences for the PC step sequencer
module tb_pc_step_sequencer;
  logic clk = 0, rst = 1, button = 1, run_mode = 0, resume = 0, branch_valid = 0, bp_en = 0;
  logic [31:0] branch_target = 0, bp_addr = 0, pc_address;
  logic [29:0] word_address;
  logic step_pulse, halted;
  int total = 0, bad = 0, cyc = 0, pulse_tot = 0, p0, np, last, exp_pc;
  bit ok;

  typedef struct {
    logic        bv;
    logic [31:0] tgt;
    logic [31:0] pc;
    logic [29:0] wa;
  } vec_t;
  vec_t tbl[8];

  pc_step_sequencer #(
    .ADDR_W(32), .INSTR_BYTES(4), .RESET_VECTOR(0), .PC_LIMIT(32), .DEB_CYCLES(4), .RUN_DIV(3)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .run_mode(run_mode), .resume(resume),
    .branch_valid(branch_valid), .branch_target(branch_target), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc_address(pc_address), .word_address(word_address), .step_pulse(step_pulse), .halted(halted)
  );

  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc++;
    if (step_pulse === 1'b1) pulse_tot++;
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic press(input logic bv, input logic [31:0] tgt);
    branch_valid = bv;
    branch_target = tgt;
    p0 = pulse_tot;
    button = 0;
    repeat (14) @(negedge clk);
    button = 1;
    repeat (10) @(negedge clk);
    branch_valid = 0;
    np = pulse_tot - p0;
  endtask

  task automatic wait_pulse(output bit got);
    got = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (step_pulse) begin
        got = 1;
        break;
      end
    end
  endtask

  initial begin
    tbl[0] = '{1'b0, 32'h0,  32'd4,  30'd1};
    tbl[1] = '{1'b0, 32'h0,  32'd8,  30'd2};
    tbl[2] = '{1'b0, 32'h0,  32'd12, 30'd3};
    tbl[3] = '{1'b1, 32'h13, 32'h10, 30'd4};
    tbl[4] = '{1'b1, 32'h40, 32'd0,  30'd0};
    tbl[5] = '{1'b0, 32'h0,  32'd4,  30'd1};
    tbl[6] = '{1'b1, 32'h1C, 32'h1C, 30'd7};
    tbl[7] = '{1'b0, 32'h0,  32'd0,  30'd0};
    repeat (2) @(negedge clk);
    chk("reset_pc", pc_address, 0);
    chk("reset_word", word_address, 0);
    chk("reset_halted", halted, 0);
    chk("reset_pulse", step_pulse, 0);
    rst = 0;
    p0 = pulse_tot;
    repeat (12) @(negedge clk);
    chk("idle_no_press", pulse_tot - p0, 0);

    foreach (tbl[i]) begin
      press(tbl[i].bv, tbl[i].tgt);
      chk("vec_pulses", np, 1);
      chk("vec_pc", pc_address, tbl[i].pc);
      chk("vec_word", word_address, tbl[i].wa);
      chk("vec_halted", halted, 0);
    end

    p0 = pulse_tot;
    for (int t = 0; t < 5; t++) begin
      button = t[0];
      repeat (2) @(negedge clk);
    end
    button = 0;
    repeat (10) @(negedge clk);
    button = 1;
    repeat (10) @(negedge clk);
    chk("bounce_pulses", pulse_tot - p0, 1);
    chk("bounce_pc", pc_address, 4);

    branch_valid = 1;
    branch_target = 32'h10;
    p0 = pulse_tot;
    repeat (10) @(negedge clk);
    branch_valid = 0;
    chk("branch_no_step_pulses", pulse_tot - p0, 0);
    chk("branch_no_step_pc", pc_address, 4);

    run_mode = 1;
    exp_pc = 4;
    last = 0;
    for (int k = 0; k < 7; k++) begin
      wait_pulse(ok);
      chk("run_pulse_seen", 32'(ok), 1);
      if (k > 0) chk("run_interval", cyc - last, 3);
      last = cyc;
      exp_pc = exp_pc + 4 >= 32 ? 0 : exp_pc + 4;
      @(negedge clk);
      chk("run_pc", pc_address, exp_pc);
    end

    ok = 0;
    for (int k = 0; k < 10; k++) begin
      wait_pulse(ok);
      @(negedge clk);
      if (pc_address == 16) break;
    end
    chk("run_reach16", pc_address, 16);
    #2 rst = 1;
    #1;
    chk("async_rst_pc", pc_address, 0);
    chk("async_rst_halted", halted, 0);

    bp_en = 1;
    bp_addr = 8;
    repeat (2) @(negedge clk);
    rst = 0;
    for (int k = 0; k < 6; k++) begin
      wait_pulse(ok);
      @(negedge clk);
      if (halted) break;
    end
    chk("bp_halted", halted, 1);
    chk("bp_pc", pc_address, 8);
    p0 = pulse_tot;
    repeat (20) @(negedge clk);
    chk("bp_no_pulses", pulse_tot - p0, 0);
    chk("bp_hold_pc", pc_address, 8);
    chk("bp_still_halted", halted, 1);
    resume = 1;
    @(negedge clk);
    resume = 0;
    chk("resume_unhalt", halted, 0);
    wait_pulse(ok);
    chk("resume_pulse_seen", 32'(ok), 1);
    @(negedge clk);
    chk("resume_pc", pc_address, 12);

    run_mode = 0;
    bp_en = 0;
    button = 0;
    repeat (3) @(negedge clk);
    rst = 1;
    repeat (2) @(negedge clk);
    rst = 0;
    p0 = pulse_tot;
    repeat (15) @(negedge clk);
    chk("held_no_press", pulse_tot - p0, 0);
    chk("held_pc", pc_address, 0);
    button = 1;
    repeat (12) @(negedge clk);
    press(0, 0);
    chk("repress_pulses", np, 1);
    chk("repress_pc", pc_address, 4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
